// File: rtl/gmii_arb_pkg.sv
// Shared encodings and constants for the GMII RX packet arbiter.
package gmii_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS  = 2'b01,
        DRAIN = 2'b10
    } arb_state_t;

    localparam int NUM_PORTS = 2;
    localparam logic [7:0] TMO_FILL_BYTE = 8'h00;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; the only home of the arbitration policy.
module rr_pick2
    import gmii_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_grant,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] pick
);

    always_comb begin
        pick = '0;
        if (en) begin
            // With both requesting, the port that did not own the last packet wins.
            if (req == 2'b11) begin
                pick = last_grant ? 2'b01 : 2'b10;
            end else begin
                pick = req;
            end
        end
    end

endmodule

// File: rtl/gmii_rx_pkt_arb2.sv
// Packet-granular 2:1 round-robin arbiter feeding the loopback buffer write stream,
// with forced termination of stalled packets.
module gmii_rx_pkt_arb2
    import gmii_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             wrclk,
    input  logic             wr_reset,
    input  logic [7:0]       s0_tdata,
    input  logic             s0_tvalid,
    input  logic             s0_tlast,
    input  logic             s0_tuser,
    output logic             s0_tready,
    input  logic [7:0]       s1_tdata,
    input  logic             s1_tvalid,
    input  logic             s1_tlast,
    input  logic             s1_tuser,
    output logic             s1_tready,
    input  logic             buf_alf,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] tmo_cnt
);

    localparam int TMR_W = 16;

    arb_state_t           state_reg, state_next;
    logic [1:0]           grant_reg, grant_next;
    logic                 last_grant_reg, last_grant_next;
    logic [TMR_W-1:0]     idle_tmr_reg;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] ready_vec;
    logic [CNT_W-1:0]     pkt_cnt_vec [NUM_PORTS];
    logic [CNT_W-1:0]     tmo_cnt_reg;
    logic [7:0]           m_tdata_reg;
    logic                 m_tvalid_reg, m_tlast_reg, m_tuser_reg;

    logic       g_sel;
    logic [7:0] sel_data;
    logic       sel_valid, sel_last, sel_user;
    logic       pass_beat, pass_end, tmo_hit, drain_end;

    rr_pick2 u_pick (
        .req        ({s1_tvalid, s0_tvalid}),
        .last_grant (last_grant_reg),
        .en         (~buf_alf),
        .pick       (pick)
    );

    assign g_sel     = grant_reg[1];
    assign sel_data  = g_sel ? s1_tdata  : s0_tdata;
    assign sel_valid = g_sel ? s1_tvalid : s0_tvalid;
    assign sel_last  = g_sel ? s1_tlast  : s0_tlast;
    assign sel_user  = g_sel ? s1_tuser  : s0_tuser;

    assign pass_beat = (state_reg == PASS) && sel_valid;
    assign pass_end  = pass_beat && sel_last;
    // A beat arriving in the threshold cycle wins over the timeout.
    assign tmo_hit   = (state_reg == PASS) && !sel_valid &&
                       (idle_tmr_reg == TMR_W'(TIMEOUT_CYC - 1));
    assign drain_end = (state_reg == DRAIN) && sel_valid && sel_last;

    always_ff @(posedge wrclk or negedge wr_reset) begin
        if (!wr_reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                grant_next = 2'b00;
                if (pick != 2'b00) begin
                    state_next = PASS;
                    grant_next = pick;
                end
            end
            PASS: begin
                if (pass_end) begin
                    state_next      = IDLE;
                    grant_next      = 2'b00;
                    last_grant_next = g_sel;
                end else if (tmo_hit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_next      = IDLE;
                    grant_next      = 2'b00;
                    last_grant_next = g_sel;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ready_vec[i] = ((state_reg == PASS) || (state_reg == DRAIN)) && grant_reg[i];
        end
    end

    always_ff @(posedge wrclk or negedge wr_reset) begin
        if (!wr_reset) begin
            m_tdata_reg  <= 8'h00;
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            m_tuser_reg  <= 1'b0;
            idle_tmr_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else begin
            m_tvalid_reg <= pass_beat || tmo_hit;
            if (pass_beat) begin
                m_tdata_reg <= sel_data;
                m_tlast_reg <= sel_last;
                m_tuser_reg <= sel_user;
            end else if (tmo_hit) begin
                m_tdata_reg <= TMO_FILL_BYTE;
                m_tlast_reg <= 1'b1;
                m_tuser_reg <= 1'b1;
            end else begin
                m_tdata_reg <= 8'h00;
                m_tlast_reg <= 1'b0;
                m_tuser_reg <= 1'b0;
            end
            if ((state_reg == PASS) && !sel_valid && !tmo_hit) begin
                idle_tmr_reg <= idle_tmr_reg + TMR_W'(1);
            end else begin
                idle_tmr_reg <= '0;
            end
            if (tmo_hit) begin
                tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge wrclk or negedge wr_reset) begin
            if (!wr_reset) begin
                cnt_reg <= '0;
            end else if (pass_end && grant_reg[gi]) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign pkt_cnt_vec[gi] = cnt_reg;
    end

    assign s0_tready = ready_vec[0];
    assign s1_tready = ready_vec[1];
    assign m_tdata   = m_tdata_reg;
    assign m_tvalid  = m_tvalid_reg;
    assign m_tlast   = m_tlast_reg;
    assign m_tuser   = m_tuser_reg;
    assign grant     = grant_reg;
    assign pkt_cnt0  = pkt_cnt_vec[0];
    assign pkt_cnt1  = pkt_cnt_vec[1];
    assign tmo_cnt   = tmo_cnt_reg;

endmodule
